multiplexer_4x8: RTL and testbench
==================================

Name: multiplexer_4x8

Overview:
- Four-input, WIDTH-bit (default 8) data selector in the ALU datapath; forwards one of four operand buses A0..A3 to Y.
- Selection is by the two select bits S1:S0.
- Output is registered: one clock of latency, qualified by a valid flag, so downstream ALU stages see a stable, glitch-free result.

Parameters:
- WIDTH, 8, bit width of each data input and of Y.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- S0  input  1  select bit 0 (LSB of select code).
- S1  input  1  select bit 1 (MSB of select code).
- A0  input  WIDTH  data input, selected by code 00.
- A1  input  WIDTH  data input, selected by code 01.
- A2  input  WIDTH  data input, selected by code 10.
- A3  input  WIDTH  data input, selected by code 11.
- in_valid  input  1  capture strobe; inputs sampled only when high.
- Y  output  WIDTH  registered selected data.
- out_valid  output  1  high for the cycle(s) Y holds a result captured on the previous in_valid edge.
- sel_q  output  2  registered copy of {S1,S0} that produced Y.

Behaviour:
- Select code sel = {S1,S0}:
  - 00 -> A0
  - 01 -> A1
  - 10 -> A2
  - 11 -> A3
- Full decode; no default or X propagation for legal 0/1 inputs.
- Reset: rst_n low forces Y = 0, sel_q = 0 and out_valid = 0 immediately, independent of clk. All are held there while rst_n is low.
- Release: first capture occurs on the first rising clk edge with rst_n high and in_valid high.
- Capture: on a rising clk edge with in_valid = 1:
  - Y <= selected input.
  - sel_q <= sel.
  - out_valid <= 1.
- Latency is exactly 1 clock from the sampling edge.
- Hold: on a rising edge with in_valid = 0, Y and sel_q hold their previous values and out_valid <= 0.
- Back-to-back: in_valid high on consecutive edges yields a new Y every cycle. There are no bubbles and no backpressure.
- Changes on A*/S* between edges have no effect on Y; only edge-sampled values matter.
- No arithmetic; data passes bit-exact. WIDTH applies uniformly to all data ports.
- Reset asserted mid-stream discards the in-flight capture. The first post-reset out_valid requires a fresh in_valid.

Optional Feature:
- Macro MULTIPLEXER_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit) = even parity (XOR-reduce) of the selected input.
  - Registered in the same edge as Y, so it always matches Y.
  - Reset value 0; holds with Y when in_valid = 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package multiplexer_pkg holds:
  - Default WIDTH constant (8).
  - 2-bit select typedef sel_t.
  - Named select constants SEL_A0 = 2'b00, SEL_A1 = 2'b01, SEL_A2 = 2'b10, SEL_A3 = 2'b11.
- One natural sub-module: mux4_comb, the purely combinational 4:1 WIDTH-bit selector (plus parity XOR under the macro).
- The top adds the output register stage, valid tracking and reset.

Test Plan:
- Reset: rst_n = 0 with A0..A3 = 8'hFF, in_valid = 1 -> Y = 8'h00, sel_q = 0, out_valid = 0 immediately, with no clock needed.
- All selects: A0 = 8'h11, A1 = 8'h22, A2 = 8'h44, A3 = 8'h88, in_valid = 1, sweep {S1,S0} = 00, 01, 10, 11 on consecutive edges -> Y = 11, 22, 44, 88 one cycle later each, out_valid continuously 1, sel_q tracks.
- Hold: capture A2 = 8'h5A, then in_valid = 0 while A2 changes to 8'hC3 and sel changes -> Y stays 8'h5A, out_valid = 0.
- Inter-edge glitch: toggle S0 and A1 several times between edges with in_valid = 1 -> Y reflects only values present at the edge.
- Mid-stream reset: stream captures, assert rst_n low asynchronously mid-cycle -> Y = 0 and out_valid = 0 at once. After release, out_valid stays 0 until the next in_valid edge.
- Parity (MULTIPLEXER_PARITY_EN):
  - A3 = 8'h07, sel = 11 -> parity = 1.
  - A0 = 8'h03, sel = 00 -> parity = 0.
  - Parity aligned with Y.

Source files
------------

// File: rtl/multiplexer_pkg.sv
// multiplexer_pkg: shared width default and select-code definitions for multiplexer_4x8
package multiplexer_pkg;
  localparam int WIDTH_DEF = 8;
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_A0 = 2'b00;
  localparam sel_t SEL_A1 = 2'b01;
  localparam sel_t SEL_A2 = 2'b10;
  localparam sel_t SEL_A3 = 2'b11;
endpackage

// File: rtl/multiplexer_4x8_mux4_comb.sv
// mux4_comb: combinational 4:1 WIDTH-bit selector; MULTIPLEXER_PARITY_EN adds XOR-reduce parity
module mux4_comb
  import multiplexer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] y
`ifdef MULTIPLEXER_PARITY_EN
  , output logic           par
`endif
);
  always_comb begin
    y = sel == SEL_A0 ? a0 :
        sel == SEL_A1 ? a1 :
        sel == SEL_A2 ? a2 : a3;
  end
`ifdef MULTIPLEXER_PARITY_EN
  assign par = ^y;
`endif
endmodule

// File: rtl/multiplexer_4x8.sv
// multiplexer_4x8: registered 4:1 WIDTH-bit selector with valid flag; MULTIPLEXER_PARITY_EN adds parity output
module multiplexer_4x8
  import multiplexer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S0,
  input  logic             S1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic [1:0]       sel_q
`ifdef MULTIPLEXER_PARITY_EN
  , output logic           parity
`endif
);
  sel_t             sel;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_d, y_q;
  sel_t             s_d, s_q;
  logic             v_d, v_q;
  assign sel = {S1, S0};
`ifdef MULTIPLEXER_PARITY_EN
  logic mux_p, p_d, p_q;
  mux4_comb #(.WIDTH(WIDTH)) u_mux (
    .sel(sel), .a0(A0), .a1(A1), .a2(A2), .a3(A3), .y(mux_y), .par(mux_p)
  );
  assign p_d    = in_valid ? mux_p : p_q;
  assign parity = p_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= 1'b0;
    else        p_q <= p_d;
  end
`else
  mux4_comb #(.WIDTH(WIDTH)) u_mux (
    .sel(sel), .a0(A0), .a1(A1), .a2(A2), .a3(A3), .y(mux_y)
  );
`endif
  always_comb begin
    y_d = in_valid ? mux_y : y_q;
    s_d = in_valid ? sel : s_q;
    v_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      s_q <= SEL_A0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      s_q <= s_d;
      v_q <= v_d;
    end
  end
  assign Y         = y_q;
  assign sel_q     = s_q;
  assign out_valid = v_q;
endmodule

// File: tb/tb_multiplexer_4x8.sv
// tb_multiplexer_4x8: scoreboard bench for multiplexer_4x8; parity checks under MULTIPLEXER_PARITY_EN
module tb_multiplexer_4x8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       S0 = 1'b0, S1 = 1'b0, in_valid = 1'b0;
  logic [7:0] A0 = '0, A1 = '0, A2 = '0, A3 = '0;
  logic [7:0] Y;
  logic       out_valid;
  logic [1:0] sel_q;
`ifdef MULTIPLEXER_PARITY_EN
  logic       parity;
`endif
  typedef struct packed {logic [7:0] y; logic [1:0] s;} exp_t;
  exp_t       sb[$];
  logic [7:0] hy = '0;
  logic [1:0] hs = '0;
  int         checks = 0, errors = 0;

  multiplexer_4x8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .S0(S0), .S1(S1),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .in_valid(in_valid), .Y(Y), .out_valid(out_valid), .sel_q(sel_q)
`ifdef MULTIPLEXER_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a0, a1, a2, a3);
    case (s)
      2'b00: pick = a0;
      2'b01: pick = a1;
      2'b10: pick = a2;
      default: pick = a3;
    endcase
  endfunction

  task automatic drive(input logic [1:0] s, input logic [7:0] a0, a1, a2, a3, input logic v);
    @(negedge clk);
    {S1, S0} = s;
    A0 = a0; A1 = a1; A2 = a2; A3 = a3;
    in_valid = v;
    if (v) sb.push_back('{y: pick(s, a0, a1, a2, a3), s: s});
  endtask

  task automatic edge_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      hy = e.y;
      hs = e.s;
      chk({tag, "_vld"}, out_valid, 1);
    end else begin
      chk({tag, "_vld"}, out_valid, 0);
    end
    chk({tag, "_y"}, Y, hy);
    chk({tag, "_sel"}, sel_q, hs);
`ifdef MULTIPLEXER_PARITY_EN
    chk({tag, "_par"}, parity, ^hy);
`endif
  endtask

  initial begin
    A0 = 8'hFF; A1 = 8'hFF; A2 = 8'hFF; A3 = 8'hFF;
    {S1, S0} = 2'b11;
    in_valid = 1'b1;
    #3;
    chk("rst_y", Y, 0);
    chk("rst_sel", sel_q, 0);
    chk("rst_vld", out_valid, 0);
    @(posedge clk); #1;
    chk("rst_hold_y", Y, 0);
    chk("rst_hold_vld", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    edge_check("post_rst_idle");

    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 8'h11, 8'h22, 8'h44, 8'h88, 1'b1);
      edge_check($sformatf("sweep%0d", i));
    end

    drive(2'b10, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b1);
    edge_check("hold_cap");
    drive(2'b01, 8'hAB, 8'hCD, 8'hC3, 8'hEF, 1'b0);
    edge_check("hold1");
    drive(2'b11, 8'h01, 8'h02, 8'hC3, 8'h04, 1'b0);
    edge_check("hold2");
    chk("hold_val", Y, 8'h5A);

    @(negedge clk);
    A0 = 8'h0F; A1 = 8'h10; {S1, S0} = 2'b00; in_valid = 1'b1;
    #1 S0 = 1'b1; A1 = 8'hAA;
    #1 S0 = 1'b0; A1 = 8'h55;
    #1 S0 = 1'b1; A1 = 8'h3C;
    sb.push_back('{y: 8'h3C, s: 2'b01});
    edge_check("glitch1");
    @(negedge clk);
    #1 S0 = 1'b1; A1 = 8'h99;
    #1 S0 = 1'b0; A0 = 8'hE7;
    sb.push_back('{y: 8'hE7, s: 2'b00});
    edge_check("glitch2");

    drive(2'b10, 8'h00, 8'h00, 8'h77, 8'h00, 1'b1);
    edge_check("pre_rst");
    drive(2'b11, 8'h00, 8'h00, 8'h00, 8'h99, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    hy = '0;
    hs = '0;
    chk("mid_rst_y", Y, 0);
    chk("mid_rst_sel", sel_q, 0);
    chk("mid_rst_vld", out_valid, 0);
    @(posedge clk); #1;
    chk("mid_rst_edge_y", Y, 0);
    chk("mid_rst_edge_vld", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    edge_check("rel_idle");
    drive(2'b01, 8'h00, 8'h6D, 8'h00, 8'h00, 1'b1);
    edge_check("rel_cap");

    drive(2'b11, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1);
    edge_check("par_a3");
`ifdef MULTIPLEXER_PARITY_EN
    chk("par_a3_one", parity, 1);
`endif
    drive(2'b00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1);
    edge_check("par_a0");
`ifdef MULTIPLEXER_PARITY_EN
    chk("par_a0_zero", parity, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
      edge_check($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
